// File: rtl/carrier_mixer.sv
// carrier_mixer
//   Carrier wipe-off mixer. Each accepted complex IF sample is paired with the
//   next buffered NCO cos/sin word and rotated by e^{-j*theta}:
//     I' = I*c + Q*s,  Q' = Q*c - I*s
//   The result is arithmetic-shifted right by SHIFT and saturated to OUT_W.
//   Pipeline: products -> sum/shift/saturate -> output register (3 cycles).
//   The NCO stream has no backpressure and is buffered in a FIFO; a word that
//   arrives while the FIFO is full is dropped and flagged in sincos_overflow.
//
// Build option: define CARRIER_MIXER_ROUND_EN to round half up before the
//   shift; otherwise the shift truncates toward minus infinity.
//
// Ports
//   axis_aclk, axis_aresetn       clock, async active-low reset
//   clear                         sync flush of FIFO, pipeline, counter, flag
//   sincos_in, sincos_valid       NCO word {sin, cos}, strobe
//   s_axis_tdata/tvalid/tready/tlast   input samples {Q, I}
//   m_axis_tdata/tvalid/tready/tlast   output samples {Q', I'}
//   sample_count                  output handshakes in the current block
//   sincos_overflow               sticky NCO drop flag
module carrier_mixer #(
   parameter int IQ_W       = 16,
   parameter int CS_W       = 16,
   parameter int OUT_W      = 16,
   parameter int SHIFT      = 7,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                axis_aclk,
   input  logic                axis_aresetn,
   input  logic                clear,
   input  logic [CS_W-1:0]     sincos_in,
   input  logic                sincos_valid,
   input  logic [2*IQ_W-1:0]   s_axis_tdata,
   input  logic                s_axis_tvalid,
   output logic                s_axis_tready,
   input  logic                s_axis_tlast,
   output logic [2*OUT_W-1:0]  m_axis_tdata,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic                m_axis_tlast,
   output logic [15:0]         sample_count,
   output logic                sincos_overflow
);

   localparam int HW     = CS_W / 2;
   localparam int PROD_W = IQ_W + HW;
   localparam int SUM_W  = PROD_W + 1;
   // One spare bit so the rounding bias can never wrap the sum.
   localparam int EXT_W  = SUM_W + 1;
   localparam int AW     = $clog2(FIFO_DEPTH);

   // ---------------- NCO FIFO ----------------
   logic [CS_W-1:0] fifo_mem_q [FIFO_DEPTH];
   logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic            fifo_empty, fifo_full, fifo_push, fifo_pop;
   logic            ovf_q, ovf_d;
   logic            pipe_en, join_fire;
   logic            out_valid_q;

   assign pipe_en    = ~out_valid_q | m_axis_tready;
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign s_axis_tready = pipe_en & ~fifo_empty;
   assign join_fire     = s_axis_tvalid & s_axis_tready;
   assign fifo_pop      = join_fire;
   // A pop in the same cycle frees the slot, so a write into a full FIFO succeeds.
   assign fifo_push     = sincos_valid & (~fifo_full | fifo_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      if (fifo_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (fifo_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      if (sincos_valid & fifo_full & ~fifo_pop) ovf_d = 1'b1;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         ovf_d    = 1'b0;
      end
   end

   always_ff @(posedge axis_aclk) begin
      if (fifo_push & ~clear) fifo_mem_q[wr_ptr_q[AW-1:0]] <= sincos_in;
   end

   // ---------------- stage 1: products ----------------
   logic [CS_W-1:0]          nco_word;
   logic signed [IQ_W-1:0]   smp_i, smp_q;
   logic signed [HW-1:0]     nco_c, nco_s;
   logic signed [PROD_W-1:0] p_ic_d, p_qs_d, p_qc_d, p_is_d;
   logic signed [PROD_W-1:0] p_ic_q, p_qs_q, p_qc_q, p_is_q;
   logic                     s1_valid_q, s1_last_q;

   assign nco_word = fifo_mem_q[rd_ptr_q[AW-1:0]];
   assign nco_c    = $signed(nco_word[HW-1:0]);
   assign nco_s    = $signed(nco_word[CS_W-1:HW]);
   assign smp_i    = $signed(s_axis_tdata[IQ_W-1:0]);
   assign smp_q    = $signed(s_axis_tdata[2*IQ_W-1:IQ_W]);

   always_comb begin
      p_ic_d = PROD_W'(smp_i) * PROD_W'(nco_c);
      p_qs_d = PROD_W'(smp_q) * PROD_W'(nco_s);
      p_qc_d = PROD_W'(smp_q) * PROD_W'(nco_c);
      p_is_d = PROD_W'(smp_i) * PROD_W'(nco_s);
   end

   // ---------------- stage 2: sum, shift, saturate ----------------
   logic signed [EXT_W-1:0] sum_i, sum_q, rnd_i, rnd_q, shf_i, shf_q;
   logic [OUT_W-1:0]        sat_i_d, sat_q_d, s2_i_q, s2_q_q;
   logic                    s2_valid_q, s2_last_q;

   function automatic logic [OUT_W-1:0] saturate(input logic signed [EXT_W-1:0] v);
      // In range when every bit above the output sign bit matches it.
      if ((&v[EXT_W-1:OUT_W-1]) || ~(|v[EXT_W-1:OUT_W-1]))
         return v[OUT_W-1:0];
      else if (v[EXT_W-1])
         return {1'b1, {(OUT_W-1){1'b0}}};
      else
         return {1'b0, {(OUT_W-1){1'b1}}};
   endfunction

`ifdef CARRIER_MIXER_ROUND_EN
   localparam logic signed [EXT_W-1:0] RND_BIAS = EXT_W'(1) <<< (SHIFT-1);
`endif

   always_comb begin
      sum_i = EXT_W'(p_ic_q) + EXT_W'(p_qs_q);
      sum_q = EXT_W'(p_qc_q) - EXT_W'(p_is_q);
`ifdef CARRIER_MIXER_ROUND_EN
      rnd_i = sum_i + RND_BIAS;
      rnd_q = sum_q + RND_BIAS;
`else
      rnd_i = sum_i;
      rnd_q = sum_q;
`endif
      shf_i   = rnd_i >>> SHIFT;
      shf_q   = rnd_q >>> SHIFT;
      sat_i_d = saturate(shf_i);
      sat_q_d = saturate(shf_q);
   end

   // ---------------- stage 3: output + block counter ----------------
   logic [2*OUT_W-1:0] out_data_q;
   logic               out_last_q;
   logic [15:0]        cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (out_valid_q & m_axis_tready)
         cnt_d = out_last_q ? 16'd0 : cnt_q + 16'd1;
      if (clear) cnt_d = 16'd0;
   end

   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         ovf_q       <= 1'b0;
         cnt_q       <= 16'd0;
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         p_ic_q      <= '0;
         p_qs_q      <= '0;
         p_qc_q      <= '0;
         p_is_q      <= '0;
         s2_valid_q  <= 1'b0;
         s2_last_q   <= 1'b0;
         s2_i_q      <= '0;
         s2_q_q      <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         cnt_q    <= cnt_d;
         if (clear) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
         end else if (pipe_en) begin
            s1_valid_q  <= join_fire;
            s1_last_q   <= s_axis_tlast & join_fire;
            p_ic_q      <= p_ic_d;
            p_qs_q      <= p_qs_d;
            p_qc_q      <= p_qc_d;
            p_is_q      <= p_is_d;
            s2_valid_q  <= s1_valid_q;
            s2_last_q   <= s1_last_q;
            s2_i_q      <= sat_i_d;
            s2_q_q      <= sat_q_d;
            out_valid_q <= s2_valid_q;
            out_last_q  <= s2_last_q;
            out_data_q  <= {s2_q_q, s2_i_q};
         end
      end
   end

   assign m_axis_tdata    = out_data_q;
   assign m_axis_tvalid   = out_valid_q;
   assign m_axis_tlast    = out_last_q;
   assign sample_count    = cnt_q;
   assign sincos_overflow = ovf_q;

endmodule

// File: tb/tb_carrier_mixer.sv
module tb_carrier_mixer;

   logic        axis_aclk = 1'b0;
   logic        axis_aresetn;
   logic        clear;
   logic [15:0] sincos_in;
   logic        sincos_valid;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic        s_axis_tlast;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic [15:0] sample_count;
   logic        sincos_overflow;

   int n_cmp = 0;
   int n_err = 0;

`ifdef CARRIER_MIXER_ROUND_EN
   localparam logic [15:0] EXP_64 = 16'd64;
`else
   localparam logic [15:0] EXP_64 = 16'd63;
`endif

   carrier_mixer dut (
      .axis_aclk       (axis_aclk),
      .axis_aresetn    (axis_aresetn),
      .clear           (clear),
      .sincos_in       (sincos_in),
      .sincos_valid    (sincos_valid),
      .s_axis_tdata    (s_axis_tdata),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tready   (s_axis_tready),
      .s_axis_tlast    (s_axis_tlast),
      .m_axis_tdata    (m_axis_tdata),
      .m_axis_tvalid   (m_axis_tvalid),
      .m_axis_tready   (m_axis_tready),
      .m_axis_tlast    (m_axis_tlast),
      .sample_count    (sample_count),
      .sincos_overflow (sincos_overflow)
   );

   always #5 axis_aclk = ~axis_aclk;

   task automatic tick();
      @(posedge axis_aclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One NCO word, one sample, then follow it through the 3-cycle pipe.
   task automatic mix_one(input logic [7:0] c, input logic [7:0] s,
                          input logic [15:0] i, input logic [15:0] q,
                          input logic [15:0] ei, input logic [15:0] eq,
                          input string tag);
      sincos_in    = {s, c};
      sincos_valid = 1'b1;
      tick();
      sincos_valid  = 1'b0;
      s_axis_tdata  = {q, i};
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = 1'b0;
      check({tag, "_ready"}, s_axis_tready, 1);
      tick();
      s_axis_tvalid = 1'b0;
      check({tag, "_v1"}, m_axis_tvalid, 0);
      tick();
      check({tag, "_v2"}, m_axis_tvalid, 0);
      tick();
      check({tag, "_v3"}, m_axis_tvalid, 1);
      check({tag, "_I"}, m_axis_tdata[15:0], ei);
      check({tag, "_Q"}, m_axis_tdata[31:16], eq);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      axis_aresetn  = 1'b0;
      clear         = 1'b0;
      sincos_in     = '0;
      sincos_valid  = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'b1;
      tick();
      tick();
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_tdata", m_axis_tdata, 0);
      check("rst_tlast", m_axis_tlast, 0);
      check("rst_count", sample_count, 0);
      check("rst_ovf", sincos_overflow, 0);
      check("rst_sready", s_axis_tready, 0);
      axis_aresetn = 1'b1;
      tick();

      // Directed arithmetic vectors.
      mix_one(8'd127, 8'd0,   16'd100,  16'd0,    16'd99,   16'd0,    "i100");
      mix_one(8'd127, 8'd0,   16'd64,   16'd0,    EXP_64,   16'd0,    "i64");
      mix_one(8'd0,   8'd127, 16'd0,    16'd100,  16'd99,   16'd0,    "q100");
      mix_one(8'd127, 8'd127, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'd0,    "satpos");
      mix_one(8'd127, 8'h80,  16'h8000, 16'h7FFF, 16'h8000, 16'hFEFF, "satneg");
      check("count_after5", sample_count, 5);

      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clr_count", sample_count, 0);
      check("clr_ovf0", sincos_overflow, 0);

      // Fill the FIFO, then one more word overflows.
      sincos_in    = {8'd0, 8'd127};
      sincos_valid = 1'b1;
      for (int k = 0; k < 8; k++) tick();
      check("fill8_ovf", sincos_overflow, 0);
      tick();
      sincos_valid = 1'b0;
      check("fill9_ovf", sincos_overflow, 1);

      // 8 samples under random downstream ready; tlast on sample 5.
      fork
         begin
            logic acc;
            int   w;
            #1;
            for (int k = 1; k <= 8; k++) begin
               s_axis_tdata  = {16'd0, 16'(128 * k)};
               s_axis_tlast  = (k == 5);
               s_axis_tvalid = 1'b1;
               acc = 1'b0;
               w   = 0;
               while (!acc && w < 100) begin
                  if (s_axis_tready) acc = 1'b1;
                  @(posedge axis_aclk);
                  #2;
                  w++;
               end
               check("flow_accept", acc, 1);
            end
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
         end
         begin
            int          got;
            int          cyc;
            logic [15:0] cnt_exp;
            logic        prev_stall;
            logic [31:0] prev_data;
            logic        prev_last;
            got        = 0;
            cyc        = 0;
            cnt_exp    = 16'd0;
            prev_stall = 1'b0;
            prev_data  = '0;
            prev_last  = 1'b0;
            while (got < 8 && cyc < 400) begin
               m_axis_tready = 1'($urandom_range(0, 1));
               if (prev_stall) begin
                  check("hold_valid", m_axis_tvalid, 1);
                  check("hold_data", m_axis_tdata, prev_data);
                  check("hold_last", m_axis_tlast, prev_last);
               end
               check("blk_count", sample_count, cnt_exp);
               if (m_axis_tvalid && m_axis_tready) begin
                  check("flow_I", m_axis_tdata[15:0], 16'(127 * (got + 1)));
                  check("flow_Q", m_axis_tdata[31:16], 0);
                  check("flow_last", m_axis_tlast, (got == 4));
                  cnt_exp = (got == 4) ? 16'd0 : cnt_exp + 16'd1;
                  got++;
               end
               prev_stall = m_axis_tvalid && !m_axis_tready;
               prev_data  = m_axis_tdata;
               prev_last  = m_axis_tlast;
               tick();
               cyc++;
            end
            check("flow_outputs", got, 8);
            m_axis_tready = 1'b1;
         end
      join
      check("flow_count_end", sample_count, 3);
      tick();
      check("flow_no_extra", m_axis_tvalid, 0);

      // Clear with two samples in flight.
      check("pre_clr_ovf", sincos_overflow, 1);
      sincos_in    = {8'd0, 8'd127};
      sincos_valid = 1'b1;
      tick();
      tick();
      tick();
      sincos_valid  = 1'b0;
      s_axis_tdata  = {16'd0, 16'd100};
      s_axis_tvalid = 1'b1;
      tick();
      s_axis_tdata  = {16'd0, 16'd200};
      tick();
      s_axis_tvalid = 1'b0;
      clear         = 1'b1;
      tick();
      clear = 1'b0;
      check("clr_tvalid", m_axis_tvalid, 0);
      check("clr_sready", s_axis_tready, 0);
      check("clr_ovf", sincos_overflow, 0);
      check("clr_cnt", sample_count, 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("clr_drain", m_axis_tvalid, 0);
      end

      // Push and pop in the same cycle while full: no overflow.
      sincos_valid = 1'b1;
      for (int k = 0; k < 8; k++) tick();
      check("full_ovf0", sincos_overflow, 0);
      check("full_sready", s_axis_tready, 1);
      s_axis_tdata  = {16'd0, 16'd100};
      s_axis_tvalid = 1'b1;
      tick();
      s_axis_tvalid = 1'b0;
      check("pushpop_ovf", sincos_overflow, 0);
      tick();
      sincos_valid = 1'b0;
      check("full_push_ovf", sincos_overflow, 1);
      tick();
      check("pushpop_tvalid", m_axis_tvalid, 1);
      check("pushpop_I", m_axis_tdata[15:0], 99);
      tick();
      m_axis_tready = 1'b0;
      check("pushpop_cnt", sample_count, 1);

      // Stall a sample at the output, then reset mid-stream.
      s_axis_tvalid = 1'b1;
      tick();
      s_axis_tvalid = 1'b0;
      tick();
      tick();
      check("stall_tvalid", m_axis_tvalid, 1);
      check("stall_I", m_axis_tdata[15:0], 99);
      check("stall_sready", s_axis_tready, 0);
      tick();
      check("stall_hold", m_axis_tdata[15:0], 99);
      axis_aresetn = 1'b0;
      #1;
      check("mrst_tvalid", m_axis_tvalid, 0);
      check("mrst_tdata", m_axis_tdata, 0);
      check("mrst_count", sample_count, 0);
      check("mrst_ovf", sincos_overflow, 0);
      check("mrst_sready", s_axis_tready, 0);
      tick();
      axis_aresetn  = 1'b1;
      m_axis_tready = 1'b1;
      tick();
      check("post_rst_tvalid", m_axis_tvalid, 0);
      check("post_rst_sready", s_axis_tready, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
